// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control FSM that drives the datapath strobes.
// Define INSTR_SEQUENCER_PERF_EN to add the 32-bit 'retired' write-back counter output.
module instr_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    input  logic        alu_done,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        mem_rd,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        alu_start,
    output logic [4:0]  alu_op,
    output logic [3:0]  rd_a_sel,
    output logic [3:0]  rd_b_sel,
    output logic [3:0]  wr_sel,
    output logic        rf_wren,
    output logic        hi_in,
    output logic        lo_in,
    output logic        busy,
    output logic        halted,
    output logic        illegal
`ifdef INSTR_SEQUENCER_PERF_EN
    ,
    output logic [31:0] retired
`endif
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_F0   = 4'd1;
    localparam logic [3:0] S_F1   = 4'd2;
    localparam logic [3:0] S_F2   = 4'd3;
    localparam logic [3:0] S_DEC  = 4'd4;
    localparam logic [3:0] S_EXE  = 4'd5;
    localparam logic [3:0] S_MDW  = 4'd6;
    localparam logic [3:0] S_WB   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    logic [3:0] state_q, state_d;
    logic [4:0] op_q;
    logic [3:0] dest_q, src_a_q, src_b_q;
    logic       illegal_q;
    logic       mul_div, exe_or_mdw, wb;

    assign mul_div    = op_q[4:1] == 4'b0110;
    assign exe_or_mdw = (state_q == S_EXE) || (state_q == S_MDW);
    assign wb         = state_q == S_WB;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = run ? S_F0 : S_IDLE;
            S_F0:    state_d = S_F1;
            S_F1:    state_d = mem_rdy ? S_F2 : S_F1;
            S_F2:    state_d = S_DEC;
            S_DEC:   state_d = (ir[31:27] >= 5'b11011) ? S_HALT : S_EXE;
            S_EXE:   state_d = mul_div ? S_MDW : S_WB;
            S_MDW:   state_d = alu_done ? S_WB : S_MDW;
            S_WB:    state_d = run ? S_F0 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction fields are captured as DEC exits so EXE..WB decode from state alone.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            dest_q    <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DEC) begin
                {op_q, dest_q, src_a_q, src_b_q} <= ir[31:15];
                illegal_q <= illegal_q | (ir[31:29] == 3'b111);
            end
        end
    end

    assign pc_out    = state_q == S_F0;
    assign mar_in    = state_q == S_F0;
    assign inc_pc    = state_q == S_F0;
    assign mem_rd    = state_q == S_F1;
    assign mdr_in    = (state_q == S_F1) && mem_rdy;
    assign ir_in     = state_q == S_F2;
    assign alu_start = state_q == S_EXE;
    assign alu_op    = exe_or_mdw ? op_q : 5'd0;
    assign rd_a_sel  = exe_or_mdw ? src_a_q : 4'd0;
    assign rd_b_sel  = exe_or_mdw ? src_b_q : 4'd0;
    assign wr_sel    = (wb && !mul_div) ? dest_q : 4'd0;
    assign rf_wren   = wb && !mul_div && (dest_q != 4'd0);
    assign hi_in     = wb && mul_div;
    assign lo_in     = wb && mul_div;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = state_q == S_HALT;
    assign illegal   = illegal_q;

`ifdef INSTR_SEQUENCER_PERF_EN
    logic [31:0] retired_q;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) retired_q <= '0;
        else if (wb) retired_q <= retired_q + 32'd1;
    end
    assign retired = retired_q;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized instruction streams checked cycle-by-cycle against a phase-timeline model.
module tb_instr_sequencer;
    typedef struct packed {
        logic       pc_out, mar_in, inc_pc, mem_rd, mdr_in, ir_in, alu_start;
        logic [4:0] alu_op;
        logic [3:0] ra, rb, ws;
        logic       rf_wren, hi_in, lo_in, busy, halted, illegal;
    } outs_t;

    logic        clk = 1'b0, clr, run, mem_rdy, alu_done;
    logic [31:0] ir;
    logic        pc_out, mar_in, inc_pc, mem_rd, mdr_in, ir_in, alu_start;
    logic [4:0]  alu_op;
    logic [3:0]  rd_a_sel, rd_b_sel, wr_sel;
    logic        rf_wren, hi_in, lo_in, busy, halted, illegal;
    outs_t       obs;
    int          passed = 0, total = 0, retired_exp = 0;
`ifdef INSTR_SEQUENCER_PERF_EN
    logic [31:0] retired;
`endif

    instr_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_rdy(mem_rdy), .alu_done(alu_done),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .mem_rd(mem_rd), .mdr_in(mdr_in),
        .ir_in(ir_in), .alu_start(alu_start), .alu_op(alu_op), .rd_a_sel(rd_a_sel),
        .rd_b_sel(rd_b_sel), .wr_sel(wr_sel), .rf_wren(rf_wren), .hi_in(hi_in), .lo_in(lo_in),
        .busy(busy), .halted(halted), .illegal(illegal)
`ifdef INSTR_SEQUENCER_PERF_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;
    assign obs = {pc_out, mar_in, inc_pc, mem_rd, mdr_in, ir_in, alu_start, alu_op,
                  rd_a_sel, rd_b_sel, wr_sel, rf_wren, hi_in, lo_in, busy, halted, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1 check("clr_async", 32'(obs), 32'd0);
        #2 clr = 1'b0;
        run = 1'b0;
        retired_exp = 0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        run = 1'b1;
        mem_rdy = 1'($urandom);
        alu_done = 1'($urandom);
        @(negedge clk);
        check("idle", 32'(obs), 32'd0);
    endtask

    // Expected timeline: F0, (w+1) F1, F2, DEC, then EXE, m MDW (mul/div only), WB.
    task automatic instr(input logic [4:0] op, input logic [3:0] d, input logic [3:0] a,
                         input logic [3:0] b, input int w, input int m, input logic run_after,
                         input int abort_at);
        bit halt = op >= 5'd27;
        bit md = (op == 5'd12) || (op == 5'd13);
        int mm = md ? m : 0;
        int n = halt ? 4 + w : 6 + w + mm;
        for (int c = 0; c < n; c++) begin
            outs_t e;
            bit in_f1, in_mdw;
            in_f1 = (c >= 1) && (c <= 1 + w);
            in_mdw = (c >= 5 + w) && (c < 5 + w + mm);
            @(posedge clk); #1;
            ir = {op, d, a, b, 15'($urandom)};
            run = (c == n - 1 && !halt) ? run_after : 1'($urandom);
            mem_rdy = in_f1 ? (c == 1 + w) : 1'($urandom);
            alu_done = in_mdw ? (c == 4 + w + mm) : 1'($urandom);
            e = '0;
            e.busy = 1'b1;
            if (c == 0) {e.pc_out, e.mar_in, e.inc_pc} = 3'b111;
            else if (in_f1) begin
                e.mem_rd = 1'b1;
                e.mdr_in = (c == 1 + w);
            end else if (c == 2 + w) e.ir_in = 1'b1;
            else if (c >= 4 + w && c < n - 1) begin
                e.alu_start = (c == 4 + w);
                e.alu_op = op;
                e.ra = a;
                e.rb = b;
            end else if (c == n - 1 && !halt) begin
                e.hi_in = md;
                e.lo_in = md;
                e.ws = md ? 4'd0 : d;
                e.rf_wren = !md && (d != 4'd0);
            end
            @(negedge clk);
            check($sformatf("op%0d_d%0d_c%0d", op, d, c), 32'(obs), 32'(e));
            if (c == abort_at) begin
                pulse_clr();
                return;
            end
            if (c == n - 1 && !halt) retired_exp++;
        end
    endtask

    task automatic halt_cycles(input bit ill);
        for (int i = 0; i < 4; i++) begin
            outs_t e;
            @(posedge clk); #1;
            run = 1'($urandom);
            e = '0;
            e.halted = 1'b1;
            e.illegal = ill;
            @(negedge clk);
            check($sformatf("halt%0d", i), 32'(obs), 32'(e));
        end
    endtask

    initial begin
        clr = 1'b1; run = 1'b1; mem_rdy = 1'b1; alu_done = 1'b1; ir = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 32'(obs), 32'd0);
        clr = 1'b0; run = 1'b0;
        idle_cycle();
        instr(5'd1, 4'd3, 4'd1, 4'd2, 0, 0, 1'b1, -1);
        instr(5'd12, 4'd5, 4'd6, 4'd7, 0, 4, 1'b0, -1);
        idle_cycle();
        instr(5'd2, 4'd0, 4'd4, 4'd9, 3, 0, 1'b1, -1);
        instr(5'd13, 4'd8, 4'd1, 4'd1, 1, 5, 1'b0, 7);
        idle_cycle();
        instr(5'd3, 4'd2, 4'd5, 4'd6, 4, 0, 1'b0, 3);
        idle_cycle();
        instr(5'd30, 4'd1, 4'd2, 4'd3, 1, 0, 1'b1, -1);
        halt_cycles(1'b1);
        @(negedge clk);
        pulse_clr();
        idle_cycle();
        for (int k = 0; k < 40; k++) begin
            logic [4:0] op;
            logic ra;
            op = ($urandom_range(0, 3) == 0) ? 5'(12 + $urandom_range(0, 1)) : 5'($urandom_range(0, 26));
            ra = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                instr(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(1, 4), ra, $urandom_range(0, 4));
                idle_cycle();
            end else begin
                instr(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(1, 4), ra, -1);
                if (!ra) idle_cycle();
            end
        end
`ifdef INSTR_SEQUENCER_PERF_EN
        @(negedge clk);
        check("retired", retired, 32'(retired_exp + ((run === 1'b1 && busy) ? 0 : 0)));
`endif
        instr(5'd27, 4'd1, 4'd1, 4'd1, 0, 0, 1'b1, -1);
        halt_cycles(1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have: clk  in  1  single clock; all state changes on rising edge.
REQ-002 The block SHALL have: clr  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have: run  in  1  start/continue; sampled in IDLE and at each instruction boundary.
REQ-004 The block SHALL have: ir  in  32  instruction word; opcode ir[31:27], dest ir[26:23], srcA ir[22:19], srcB ir[18:15].
REQ-005 The block SHALL have: mem_rdy  in  1  memory read data valid.
REQ-006 The block SHALL have: alu_done  in  1  multi-cycle mul/div complete.
REQ-007 The block SHALL have: pc_out, mar_in, inc_pc, mem_rd, mdr_in, ir_in  out  1 each  fetch-path strobes.
REQ-008 The block SHALL have: alu_start  out  1  one-cycle ALU launch pulse; alu_op  out  5  opcode to ALU.
REQ-009 The block SHALL have: rd_a_sel, rd_b_sel, wr_sel  out  4 each  register-file selects; rf_wren  out  1  register-file write enable.
REQ-010 The block SHALL have: hi_in, lo_in  out  1 each  HI/LO latch enables.
REQ-011 The block SHALL have: busy, halted, illegal  out  1 each  status.

Function
REQ-012 States SHALL be IDLE, F0, F1, F2, DEC, EXE, MDW, WB, HALT.
REQ-013 IDLE: all strobes 0; run=1 -> F0 next edge; else stay.
REQ-014 F0 (1 cycle): pc_out=mar_in=inc_pc=1; -> F1.
REQ-015 F1: mem_rd=1 each cycle; mdr_in=1 only in the cycle mem_rdy=1; mem_rdy=1 -> F2, else stay (no timeout).
REQ-016 F2 (1 cycle): ir_in=1; -> DEC.
REQ-017 DEC (1 cycle): ir now valid; opcode 11011 -> HALT; opcode 11100-11111 -> HALT and set illegal; else -> EXE.
REQ-018 EXE: alu_op=opcode, rd_a_sel=srcA, rd_b_sel=srcB, alu_start=1 for exactly one cycle; opcode 01100 (mul) or 01101 (div) -> MDW; other -> WB.
REQ-019 MDW: alu_op/rd selects held, alu_start=0; alu_done=1 -> WB, else stay.
REQ-020 WB (1 cycle): mul/div -> hi_in=lo_in=1, rf_wren=0; other ops -> wr_sel=dest, rf_wren=1 unless dest=0000 (r0 never written).
REQ-021 WB exit: run=1 -> F0; run=0 -> IDLE.
REQ-022 Instruction latency SHALL be 6 cycles (F0..WB) with mem_rdy in first F1 cycle and non-mul/div; plus each extra mem wait and MDW cycle.
REQ-023 alu_done outside MDW and mem_rdy outside F1 SHALL be ignored.
REQ-024 busy=1 in every state except IDLE and HALT; halted=1 only in HALT.
REQ-025 HALT SHALL be exited only by clr; run ignored.
REQ-026 run deassertion mid-instruction SHALL NOT abort it; checked only at WB.
REQ-027 All outputs SHALL be registered-state decodes (Moore) except mdr_in (Mealy on mem_rdy in F1).

Reset
REQ-028 clr=1 SHALL asynchronously force IDLE, all strobes, selects, alu_op, status (incl. sticky illegal) to 0, at any time incl. mid-F1 or mid-MDW.
REQ-029 First F0 after clr deassert requires run=1 sampled on a rising edge with clr=0.

Configuration
REQ-030 Macro INSTR_SEQUENCER_PERF_EN: defined -> extra output retired  out  32, counts WB cycles, wraps 0xFFFFFFFF->0, cleared by clr; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-031 clr pulse, run=1, mem_rdy=1 constant, ir=add dest=3 srcA=1 srcB=2 -> strobes F0..WB over 6 cycles, rf_wren=1 wr_sel=3 in cycle 6, then F0 again.
REQ-032 ir=mul (01100) dest=5, alu_done asserted 4 cycles after alu_start -> hi_in=lo_in=1 in WB, rf_wren=0, total 10 cycles.
REQ-033 ir dest=0000 add -> WB with rf_wren=0; mem_rdy delayed 3 cycles -> mem_rd held 4 cycles, mdr_in single pulse.
REQ-034 ir opcode 11110 -> HALT, illegal=1, halted=1, busy=0; run toggling no effect; clr -> IDLE, illegal=0.
REQ-035 clr asserted during MDW -> immediate IDLE, all outputs 0; run dropped in EXE -> instruction completes, then IDLE.
REQ-036 With INSTR_SEQUENCER_PERF_EN: 3 retired instructions -> retired=3; preload-equivalent run at 0xFFFFFFFF -> wraps to 0.
